c6288_vector_sequencer: RTL and testbench

Synthesizable controller that replaces the behavioural apply/wait/capture loop around the c6288 16x16 multiplier netlist. It fetches input vectors from a synchronous vector memory and drives them onto the DUT inputs. It holds each vector for a programmable settle time, captures the DUT outputs, and streams each result out over a valid/ready handshake. It sits between the vector ROM/RAM and the result sink (FIFO or UART packer) in the on-FPGA fault-simulation harness.

---
 rtl/c6288_vector_sequencer.sv | 141 ++++++++++++++
 tb/tb_c6288_vector_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c6288_vector_sequencer.sv
// Vector sequencer for the c6288 multiplier: fetches each test vector, applies it,
// waits a programmable settle time, captures the outputs and streams them out.
module c6288_vector_sequencer #(
    parameter int INPUT_WIDTH     = 32,
    parameter int OUTPUT_WIDTH    = 32,
    parameter int NUMBER_OF_TESTS = 10000,
    parameter int ADDR_WIDTH      = 14,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [INPUT_WIDTH-1:0]  mem_rdata,
    output logic [INPUT_WIDTH-1:0]  dut_in,
    input  logic [OUTPUT_WIDTH-1:0] dut_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUTPUT_WIDTH-1:0] res_data,
    output logic [ADDR_WIDTH-1:0]   res_index
);

    localparam int CNT_WIDTH = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX  = ADDR_WIDTH'(NUMBER_OF_TESTS - 1);
    localparam logic [CNT_WIDTH-1:0]  SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE     = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        EMIT,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   index_reg, index_next;
    logic [CNT_WIDTH-1:0]    settle_cnt_reg, settle_cnt_next;
    logic [INPUT_WIDTH-1:0]  dut_in_reg, dut_in_next;
    logic [OUTPUT_WIDTH-1:0] res_data_reg, res_data_next;
    logic [ADDR_WIDTH-1:0]   res_index_reg, res_index_next;
    logic                    abort_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            settle_cnt_reg <= '0;
            dut_in_reg     <= '0;
            res_data_reg   <= '0;
            res_index_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            settle_cnt_reg <= settle_cnt_next;
            dut_in_reg     <= dut_in_next;
            res_data_reg   <= res_data_next;
            res_index_reg  <= res_index_next;
        end
    end

    // DONE is deliberately excluded so a finished run always reports completion.
    assign abort_run = abort && (state_reg == FETCH || state_reg == LOAD ||
                                 state_reg == SETTLE || state_reg == EMIT);

    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        settle_cnt_next = settle_cnt_reg;
        dut_in_next     = dut_in_reg;
        res_data_next   = res_data_reg;
        res_index_next  = res_index_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    index_next = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                dut_in_next     = mem_rdata;
                settle_cnt_next = SETTLE_LOAD;
                state_next      = SETTLE;
            end
            SETTLE: begin
                settle_cnt_next = settle_cnt_reg - CNT_ONE;
                if (settle_cnt_reg == CNT_ONE) begin
                    res_data_next  = dut_out;
                    res_index_next = index_reg;
                    state_next     = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + IDX_ONE;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort freezes every datapath register; only the state returns to IDLE.
        if (abort_run) begin
            state_next      = IDLE;
            index_next      = index_reg;
            settle_cnt_next = settle_cnt_reg;
            dut_in_next     = dut_in_reg;
            res_data_next   = res_data_reg;
            res_index_next  = res_index_reg;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign mem_rd_en = (state_reg == FETCH);
    assign mem_addr  = index_reg;
    assign res_valid = (state_reg == EMIT);
    assign dut_in    = dut_in_reg;
    assign res_data  = res_data_reg;
    assign res_index = res_index_reg;

endmodule

// File: tb/tb_c6288_vector_sequencer.sv
// Bench for c6288_vector_sequencer: behavioural multiplier / delayed stubs, vector
// memory with registered read, and a result scoreboard.
module tb_c6288_vector_sequencer;

    localparam int IW = 32;
    localparam int OW = 32;
    localparam int NT = 4;
    localparam int AW = 4;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          res_ready = 1'b1;
    logic          busy, done, mem_rd_en, res_valid;
    logic [AW-1:0] mem_addr, res_index;
    logic [IW-1:0] mem_rdata, dut_in;
    logic [OW-1:0] dut_out, res_data;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] prod;
    } vec_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [OW-1:0] data;
    } sb_t;

    vec_t        tbl [NT];
    sb_t         sb [$];
    logic [31:0] mem [16];
    logic [31:0] d1, d2;
    int          mode = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_count = 0;
    int          total = 0;
    int          bad = 0;

    c6288_vector_sequencer #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUMBER_OF_TESTS(NT),
        .ADDR_WIDTH(AW), .SETTLE_CYCLES(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dut_in(dut_in), .dut_out(dut_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Stubs: mode 1 lags dut_in+1 by ST-1 cycles, mode 2 by ST cycles.
    always @(posedge clk) begin
        d1 <= dut_in + 32'd1;
        d2 <= d1;
    end

    always_comb begin
        dut_out = 32'(dut_in[15:0]) * 32'(dut_in[31:16]);
        if (mode == 1) dut_out = d1;
        else if (mode == 2) dut_out = d2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples between the input-drive negedge and the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {28'd0, res_index}, 64'hFFFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                $display("result idx=%0d data=%08h expect idx=%0d data=%08h",
                         res_index, res_data, e.idx, e.data);
                check("res_index", {60'd0, res_index}, {60'd0, e.idx});
                check("res_data", {32'd0, res_data}, {32'd0, e.data});
            end
        end
        if (rst_n && done) done_count++;
    end

    task automatic push_expected(input int m);
        for (int i = 0; i < NT; i++) begin
            sb_t e;
            logic [31:0] prev;
            prev = (i == 0) ? tbl[NT-1].vec : tbl[i-1].vec;
            e.idx = AW'(i);
            if (m == 0)      e.data = tbl[i].prod;
            else if (m == 1) e.data = tbl[i].vec + 32'd1;
            else             e.data = prev + 32'd1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Waits for done; checks run length and that done pulses exactly once.
    task automatic wait_done(input string name, input int exp_len, input bit poke_start);
        int  dc0;
        bit  got;
        dc0 = done_count;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            check({name, "_run_len"}, 64'(cyc - start_cyc + 1), 64'(exp_len));
            if (poke_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({name, "_done_once"}, 64'(done_count), 64'(dc0 + 1));
            check({name, "_idle_after"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic wait_fetch(input int idx, output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == AW'(idx)) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_fetch", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_valid(input int idx, output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid && res_index == AW'(idx)) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_valid", {63'd0, got}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
        check({name, "_res_valid"}, {63'd0, res_valid}, 64'd0);
        check({name, "_mem_rd_en"}, {63'd0, mem_rd_en}, 64'd0);
        check({name, "_mem_addr"}, {60'd0, mem_addr}, 64'd0);
        check({name, "_dut_in"}, {32'd0, dut_in}, 64'd0);
        check({name, "_res_data"}, {32'd0, res_data}, 64'd0);
        check({name, "_res_index"}, {60'd0, res_index}, 64'd0);
    endtask

    initial begin
        bit got;
        int dc;

        tbl[0] = '{vec: 32'h0003_0005, prod: 32'h0000_000F};
        tbl[1] = '{vec: 32'h00FF_00FF, prod: 32'h0000_FE01};
        tbl[2] = '{vec: 32'hFFFF_FFFF, prod: 32'hFFFE_0001};
        tbl[3] = '{vec: 32'h0000_0000, prod: 32'h0000_0000};
        for (int i = 0; i < 16; i++) mem[i] = (i < NT) ? tbl[i].vec : 32'hDEAD_BEEF;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_busy", {63'd0, busy}, 64'd0);

        // Basic run with the multiplier model
        mode = 0;
        push_expected(0);
        pulse_start();
        check("basic_fetch_rd_en", {63'd0, mem_rd_en}, 64'd1);
        check("basic_fetch_addr", {60'd0, mem_addr}, 64'd0);
        wait_done("basic", NT * (3 + ST) + 1, 1'b0);
        check("basic_dut_in_hold", {32'd0, dut_in}, {32'd0, tbl[NT-1].vec});

        // Backpressure: 7 stalled EMIT cycles on index 1
        push_expected(0);
        pulse_start();
        wait_fetch(1, got);
        res_ready = 1'b0;
        wait_valid(1, got);
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", {63'd0, res_valid}, 64'd1);
            check("bp_data", {32'd0, res_data}, {32'd0, tbl[1].prod});
            check("bp_index", {60'd0, res_index}, 64'd1);
            check("bp_no_rd", {63'd0, mem_rd_en}, 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_done("bp", NT * (3 + ST) + 1 + 7, 1'b0);

        // Settle: stub lagging ST-1 cycles is captured fresh
        mode = 1;
        push_expected(1);
        pulse_start();
        wait_done("settle", NT * (3 + ST) + 1, 1'b0);

        // Stub lagging ST cycles yields the previous vector's value
        mode = 2;
        push_expected(2);
        pulse_start();
        wait_done("stale", NT * (3 + ST) + 1, 1'b0);
        mode = 0;

        // Abort during SETTLE of index 2
        for (int i = 0; i < 2; i++) sb.push_back('{idx: AW'(i), data: tbl[i].prod});
        pulse_start();
        wait_fetch(2, got);
        @(negedge clk);
        @(negedge clk);
        dc = done_count;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, res_valid}, 64'd0);
        check("abort_index_kept", {60'd0, mem_addr}, 64'd2);
        check("abort_dut_in_hold", {32'd0, dut_in}, {32'd0, tbl[2].vec});
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'(dc));
        check("abort_still_idle", {63'd0, busy}, 64'd0);
        push_expected(0);
        pulse_start();
        check("restart_addr", {60'd0, mem_addr}, 64'd0);
        check("restart_rd_en", {63'd0, mem_rd_en}, 64'd1);
        wait_done("restart", NT * (3 + ST) + 1, 1'b0);

        // Start pulsed during EMIT and DONE is ignored
        push_expected(0);
        pulse_start();
        wait_valid(1, got);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("startfilt", NT * (3 + ST) + 1, 1'b1);
        @(negedge clk);
        check("start_in_done_ignored", {63'd0, busy}, 64'd0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {63'd0, busy}, 64'd0);
        check("start_abort_rd_en", {63'd0, mem_rd_en}, 64'd0);

        // Asynchronous reset pulse mid-EMIT
        res_ready = 1'b0;
        pulse_start();
        wait_valid(0, got);
        check("areset_pre_data", {32'd0, res_data}, {32'd0, tbl[0].prod});
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("areset");
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("areset_idle_busy", {63'd0, busy}, 64'd0);
        check("areset_idle_valid", {63'd0, res_valid}, 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
